// File: rtl/hilo_muldiv_unit_if.sv
// Operand/result bundle between the EX stage and the HI/LO multiply-divide unit.
// The pipeline side drives requests and MTHI/MTLO writes; the unit returns HI/LO and status.
interface hilo_muldiv_unit_if;
  logic        Start;
  logic [1:0]  Op;
  logic [31:0] A;
  logic [31:0] B;
  logic        HiWrite;
  logic        LoWrite;
  logic [31:0] WriteData;
  logic [31:0] Hi;
  logic [31:0] Lo;
  logic        Busy;
  logic        Done;

  modport master (
    output Start, Op, A, B, HiWrite, LoWrite, WriteData,
    input  Hi, Lo, Busy, Done
  );

  modport slave (
    input  Start, Op, A, B, HiWrite, LoWrite, WriteData,
    output Hi, Lo, Busy, Done
  );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// Iterative radix-2 MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// Define MULDIV_EARLY_OUT_EN to skip the iterations when the divisor/multiplier is zero.
module hilo_muldiv_unit #(
  parameter int ITERATIONS = 32
) (
  input logic                 Clk,
  input logic                 Reset,
  hilo_muldiv_unit_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  localparam logic [4:0] LAST = 5'(ITERATIONS - 1);

  state_t      state_q, state_d;
  logic [4:0]  cnt_q;
  logic [1:0]  op_q;
  logic [63:0] acc_q;    // mult: {partial product, multiplier}; div: {remainder, quotient}
  logic [31:0] opnd_q;   // |multiplicand| or |divisor|
  logic [31:0] a_raw_q;
  logic        b_zero_q;
  logic        neg_q;
  logic        neg_r;
  logic [31:0] hi_q, lo_q;
  logic        done_q;

  logic [32:0] mul_sum;
  logic [32:0] rem_shift;
  logic        rem_ge;
  logic [31:0] rem_sub;
  logic        signed_op;

  function automatic logic [31:0] mag(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? -v : v;
  endfunction

  assign signed_op = ~bus.Op[0];

  // NOTE: every signal assigned in an always_comb gets a default first so no latch is inferred.
  always_comb begin
    mul_sum   = {1'b0, acc_q[63:32]} + {1'b0, opnd_q};
    rem_shift = acc_q[63:31];
    rem_ge    = rem_shift >= {1'b0, opnd_q};
    rem_sub   = rem_shift[31:0] - opnd_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.Start) begin
`ifdef MULDIV_EARLY_OUT_EN
        state_d = (bus.B == 32'd0) ? FIX : CALC;
`else
        state_d = CALC;
`endif
      end
      CALC:    if (cnt_q == LAST) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cnt_q    <= '0;
      op_q     <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      a_raw_q  <= '0;
      b_zero_q <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= (state_q == FIX);
      case (state_q)
        IDLE: begin
          if (bus.HiWrite) hi_q <= bus.WriteData;
          if (bus.LoWrite) lo_q <= bus.WriteData;
          if (bus.Start) begin
            op_q     <= bus.Op;
            cnt_q    <= '0;
            a_raw_q  <= bus.A;
            b_zero_q <= (bus.B == 32'd0);
            neg_q    <= signed_op & (bus.A[31] ^ bus.B[31]);
            neg_r    <= signed_op & bus.A[31];
            if (bus.Op[1]) begin
              acc_q  <= {32'd0, mag(bus.A, signed_op)};
              opnd_q <= mag(bus.B, signed_op);
            end else begin
              acc_q  <= {32'd0, mag(bus.B, signed_op)};
              opnd_q <= mag(bus.A, signed_op);
            end
          end
        end
        CALC: begin
          cnt_q <= cnt_q + 5'd1;
          if (!op_q[1])
            acc_q <= acc_q[0] ? {mul_sum, acc_q[31:1]} : {1'b0, acc_q[63:1]};
          else if (rem_ge)
            acc_q <= {rem_sub, acc_q[30:0], 1'b1};
          else
            acc_q <= {rem_shift[31:0], acc_q[30:0], 1'b0};
        end
        FIX: begin
          if (!op_q[1]) begin
            {hi_q, lo_q} <= neg_q ? -acc_q : acc_q;
          end else if (b_zero_q) begin
            hi_q <= a_raw_q;
            lo_q <= '1;
          end else begin
            lo_q <= neg_q ? -acc_q[31:0]  : acc_q[31:0];
            hi_q <= neg_r ? -acc_q[63:32] : acc_q[63:32];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.Hi   = hi_q;
  assign bus.Lo   = lo_q;
  assign bus.Busy = (state_q != IDLE);
  assign bus.Done = done_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit: results, latency, busy-time gating of Start/MTHI/MTLO,
// and asynchronous reset mid-operation.
module tb_hilo_muldiv_unit;

  logic Clk;
  logic Reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   lat;
  int   busy_cyc;
  int   exp_lat;

  hilo_muldiv_unit_if bus_if ();

  hilo_muldiv_unit #(.ITERATIONS(32)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus_if)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called mid-cycle; the following rising edge is the Start edge.
  task automatic do_start(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus_if.Start = 1'b1;
    bus_if.Op    = op;
    bus_if.A     = a;
    bus_if.B     = b;
    @(posedge Clk);
    #1;
    bus_if.Start = 1'b0;
    bus_if.Op    = 2'b00;
    bus_if.A     = 32'h5555_AAAA;
    bus_if.B     = 32'hAAAA_5555;
  endtask

  // Counts cycles after the Start edge until Done, bounded.
  task automatic wait_done(output int cycles, output int busy);
    cycles = 0;
    busy   = 0;
    while (bus_if.Done !== 1'b1 && cycles < 60) begin
      if (bus_if.Busy === 1'b1) busy++;
      @(posedge Clk);
      #1;
      cycles++;
    end
  endtask

  initial begin
    Reset             = 1'b0;
    bus_if.Start      = 1'b0;
    bus_if.Op         = 2'b00;
    bus_if.A          = '0;
    bus_if.B          = '0;
    bus_if.HiWrite    = 1'b0;
    bus_if.LoWrite    = 1'b0;
    bus_if.WriteData  = '0;
    #12;
    check("reset_hi_lo",   {bus_if.Hi, bus_if.Lo}, 64'd0);
    check("reset_busy_done", {62'd0, bus_if.Busy, bus_if.Done}, 64'd0);
    @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk);
    #1;

    // MULT -3 * 7
    do_start(2'b00, 32'hFFFF_FFFD, 32'd7);
    wait_done(lat, busy_cyc);
    check("mult_latency", 64'(lat), 64'd33);
    check("mult_busy_cycles", 64'(busy_cyc), 64'd33);
    check("mult_busy_at_done", {63'd0, bus_if.Busy}, 64'd0);
    check("mult_result", {bus_if.Hi, bus_if.Lo}, 64'hFFFF_FFFF_FFFF_FFEB);

    // MULTU then DIV started in the Done cycle
    @(posedge Clk);
    #1;
    do_start(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(lat, busy_cyc);
    check("multu_result", {bus_if.Hi, bus_if.Lo}, 64'hFFFF_FFFE_0000_0001);
    do_start(2'b10, 32'hFFFF_FFF9, 32'd2);
    check("done_one_cycle", {62'd0, bus_if.Done, bus_if.Busy}, 64'd1);
    wait_done(lat, busy_cyc);
    check("div_back_to_back_latency", 64'(lat), 64'd33);
    check("div_neg_result", {bus_if.Hi, bus_if.Lo}, 64'hFFFF_FFFF_FFFF_FFFD);

    // DIVU by zero
    @(posedge Clk);
    #1;
`ifdef MULDIV_EARLY_OUT_EN
    exp_lat = 1;
`else
    exp_lat = 33;
`endif
    do_start(2'b11, 32'd15, 32'd0);
    wait_done(lat, busy_cyc);
    check("divz_latency", 64'(lat), 64'(exp_lat));
    check("divz_busy_cycles", 64'(busy_cyc), 64'(exp_lat));
    check("divz_result", {bus_if.Hi, bus_if.Lo}, 64'h0000_000F_FFFF_FFFF);

    // DIV overflow corner
    do_start(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(lat, busy_cyc);
    check("div_overflow_result", {bus_if.Hi, bus_if.Lo}, 64'h0000_0000_8000_0000);

    // MTHI and MTLO together while idle
    bus_if.HiWrite   = 1'b1;
    bus_if.LoWrite   = 1'b1;
    bus_if.WriteData = 32'hA5A5_A5A5;
    @(posedge Clk);
    #1;
    bus_if.HiWrite = 1'b0;
    bus_if.LoWrite = 1'b0;
    check("mthi_mtlo_both", {bus_if.Hi, bus_if.Lo}, 64'hA5A5_A5A5_A5A5_A5A5);

    // DIVU with Start and MTHI attempted while busy
    do_start(2'b11, 32'd100, 32'd7);
    repeat (9) begin
      @(posedge Clk);
      #1;
    end
    bus_if.Start     = 1'b1;
    bus_if.Op        = 2'b00;
    bus_if.A         = 32'd2;
    bus_if.B         = 32'd3;
    bus_if.HiWrite   = 1'b1;
    bus_if.WriteData = 32'hDEAD_BEEF;
    @(posedge Clk);
    #1;
    bus_if.Start   = 1'b0;
    bus_if.HiWrite = 1'b0;
    check("mthi_ignored_busy", {32'd0, bus_if.Hi}, 64'hA5A5_A5A5);
    wait_done(lat, busy_cyc);
    check("divu_ignore_latency", 64'(lat), 64'd23);
    check("divu_result", {bus_if.Hi, bus_if.Lo}, 64'h0000_0002_0000_000E);
    @(posedge Clk);
    #1;
    check("no_queued_start", {62'd0, bus_if.Busy, bus_if.Done}, 64'd0);
    bus_if.LoWrite   = 1'b1;
    bus_if.WriteData = 32'h1234_5678;
    @(posedge Clk);
    #1;
    bus_if.LoWrite = 1'b0;
    check("mtlo_idle", {bus_if.Hi, bus_if.Lo}, 64'h0000_0002_1234_5678);

    // Asynchronous reset mid-operation
    do_start(2'b00, 32'd5, 32'd5);
    repeat (19) begin
      @(posedge Clk);
      #1;
    end
    Reset = 1'b0;
    #1;
    check("async_reset_hi_lo", {bus_if.Hi, bus_if.Lo}, 64'd0);
    check("async_reset_busy", {62'd0, bus_if.Busy, bus_if.Done}, 64'd0);
    @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    check("post_reset_idle", {63'd0, bus_if.Busy}, 64'd0);
    do_start(2'b00, 32'd5, 32'd5);
    wait_done(lat, busy_cyc);
    check("restart_latency", 64'(lat), 64'd33);
    check("restart_result", {bus_if.Hi, bus_if.Lo}, 64'd25);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
